// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch port (I, read-only) and the data load/store port (D). Only one
//   transaction is outstanding at a time. Ties are broken round-robin.
//
// Ports
//   clk_i, rst_i                   clock (rising edge), async active-low reset
//   i_req_i, i_addr_i              fetch request/address, held until granted
//   i_gnt_o, i_rvalid_o, i_rdata_o fetch grant, read-data pulse, read data
//   d_req_i, d_we_i, d_addr_i,     data request, store enable, address and
//   d_wdata_i                      store data, held until granted
//   d_gnt_o, d_rvalid_o, d_rdata_o data grant, load-data pulse, load data
//   mem_req_o, mem_we_o,           memory strobe, write enable, address and
//   mem_addr_o, mem_wdata_o        write data
//   mem_rdata_i                    memory read data, MEM_LATENCY cycles after
//                                  a read strobe
module mem_arbiter #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_req_i,
  input  logic [ADDRWIDTH-1:0] i_addr_i,
  output logic                 i_gnt_o,
  output logic                 i_rvalid_o,
  output logic [DATAWIDTH-1:0] i_rdata_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [ADDRWIDTH-1:0] d_addr_i,
  input  logic [DATAWIDTH-1:0] d_wdata_i,
  output logic                 d_gnt_o,
  output logic                 d_rvalid_o,
  output logic [DATAWIDTH-1:0] d_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  localparam int            CW  = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  port_e         owner_q, owner_d;
  port_e         last_q, last_d;

  logic pick_i;
  logic i_gnt;
  logic d_gnt;
  logic done;

  // I wins unless D is also requesting and I was the most recent winner.
  assign pick_i = i_req_i && (!d_req_i || (last_q == PORT_D));

  // Gating with rst_i forces every output low while reset is held, even
  // though the grant path is combinational from the request inputs.
  assign i_gnt = rst_i && (state_q == IDLE) && pick_i;
  assign d_gnt = rst_i && (state_q == IDLE) && d_req_i && !pick_i;
  assign done  = rst_i && (state_q == WAIT) && (cnt_q == LAT);

  assign i_gnt_o     = i_gnt;
  assign d_gnt_o     = d_gnt;
  assign mem_req_o   = i_gnt || d_gnt;
  assign mem_we_o    = d_gnt && d_we_i;
  assign mem_addr_o  = d_gnt ? d_addr_i : (i_gnt ? i_addr_i : '0);
  assign mem_wdata_o = d_gnt ? d_wdata_i : '0;

  assign i_rvalid_o = done && (owner_q == PORT_I);
  assign d_rvalid_o = done && (owner_q == PORT_D);
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_gnt || d_gnt) begin
          owner_d = d_gnt ? PORT_D : PORT_I;
          last_d  = d_gnt ? PORT_D : PORT_I;
          // A store completes at grant; only reads wait for data.
          if (!(d_gnt && d_we_i)) begin
            state_d = WAIT;
            cnt_d   = ONE;
          end
        end
      end
      WAIT: begin
        // Compare before increment so the counter never wraps.
        if (cnt_q == LAT) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= PORT_I;
      last_q  <= PORT_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;      // 0: MEM_LATENCY=1 instance, 1: MEM_LATENCY=3 instance
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_gnt1, i_rv1, d_gnt1, d_rv1, mreq1, mwe1;
  logic [31:0] i_rd1, d_rd1, maddr1, mwd1, mrd1;
  logic        i_gnt3, i_rv3, d_gnt3, d_rv3, mreq3, mwe3;
  logic [31:0] i_rd3, d_rd3, maddr3, mwd3, mrd3;

  mem_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .i_req_i(i_req && !sel), .i_addr_i(i_addr),
    .i_gnt_o(i_gnt1), .i_rvalid_o(i_rv1), .i_rdata_o(i_rd1),
    .d_req_i(d_req && !sel), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt1), .d_rvalid_o(d_rv1), .d_rdata_o(d_rd1),
    .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_wdata_o(mwd1),
    .mem_rdata_i(mrd1)
  );

  mem_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n),
    .i_req_i(i_req && sel), .i_addr_i(i_addr),
    .i_gnt_o(i_gnt3), .i_rvalid_o(i_rv3), .i_rdata_o(i_rd3),
    .d_req_i(d_req && sel), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt3), .d_rvalid_o(d_rv3), .d_rdata_o(d_rd3),
    .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_wdata_o(mwd3),
    .mem_rdata_i(mrd3)
  );

  // Outputs of the instance currently under test
  logic        o_i_gnt, o_i_rv, o_d_gnt, o_d_rv, o_mreq, o_mwe;
  logic [31:0] o_i_rd, o_d_rd, o_maddr, o_mwd;
  assign o_i_gnt = sel ? i_gnt3 : i_gnt1;
  assign o_i_rv  = sel ? i_rv3  : i_rv1;
  assign o_i_rd  = sel ? i_rd3  : i_rd1;
  assign o_d_gnt = sel ? d_gnt3 : d_gnt1;
  assign o_d_rv  = sel ? d_rv3  : d_rv1;
  assign o_d_rd  = sel ? d_rd3  : d_rd1;
  assign o_mreq  = sel ? mreq3  : mreq1;
  assign o_mwe   = sel ? mwe3   : mwe1;
  assign o_maddr = sel ? maddr3 : maddr1;
  assign o_mwd   = sel ? mwd3   : mwd1;

  // Initial memory contents: word 4 (byte 0x10) holds 0xDEADBEEF.
  function automatic logic [31:0] pat(input int a);
    if (a == 4) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Memory stubs: reloaded while reset is held; read data appears exactly
  // LATENCY cycles after a read strobe and is junk otherwise.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 256; a++) mem1[a] <= pat(a);
    end else if (mreq1 && mwe1) begin
      mem1[maddr1[9:2]] <= mwd1;
    end
    pipe1 <= (mreq1 && !mwe1) ? mem1[maddr1[9:2]] : 32'hBAD0BAD0;
  end
  assign mrd1 = pipe1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 256; a++) mem3[a] <= pat(a);
    end else if (mreq3 && mwe3) begin
      mem3[maddr3[9:2]] <= mwd3;
    end
    pipe3[0] <= (mreq3 && !mwe3) ? mem3[maddr3[9:2]] : 32'hBAD0BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mrd3 = pipe3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          port;   // 0 = I, 1 = D
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] shadow[int];

  function automatic int key_of(input logic [31:0] a);
    return (sel ? 4096 : 0) + int'(a[11:0]);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (shadow.exists(key_of(a))) return shadow[key_of(a)];
    return pat(int'(a[9:2]));
  endfunction

  function automatic logic any_out();
    return |{o_i_gnt, o_i_rv, o_i_rd, o_d_gnt, o_d_rv, o_d_rd,
             o_mreq, o_mwe, o_maddr, o_mwd};
  endfunction

  // Scoreboard monitor and per-cycle invariants
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      shadow.delete();
    end else begin
      chk("one_gnt", o_i_gnt && o_d_gnt, 0);
      chk("one_rvalid", o_i_rv && o_d_rv, 0);
      chk("gnt_with_rvalid", (o_i_gnt || o_d_gnt) && (o_i_rv || o_d_rv), 0);
      chk("rdata_zero", (!o_i_rv && o_i_rd != 0) || (!o_d_rv && o_d_rd != 0), 0);
      if (o_i_rv || o_d_rv) begin
        chk("sb_rvalid_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_port", o_d_rv, e.port);
          chk("sb_data", o_d_rv ? o_d_rd : o_i_rd, e.data);
          chk("sb_cycle", cyc, e.cyc);
        end
      end
      if (o_i_gnt)
        sbq.push_back('{port: 1'b0, data: exp_word(i_addr), cyc: cyc + (sel ? 3 : 1)});
      if (o_d_gnt) begin
        if (d_we) shadow[key_of(d_addr)] = d_wdata;
        else sbq.push_back('{port: 1'b1, data: exp_word(d_addr), cyc: cyc + (sel ? 3 : 1)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string tag, output int c);
    c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_i_gnt || o_d_gnt) begin
        c = cyc;
        break;
      end
    end
    chk({tag, "_timeout"}, c < 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int c, prev, n0;

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // Single fetch, latency 1
    do_reset();
    @(negedge clk);
    chk("rst_idle_outs", any_out(), 0);
    step();
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("f1_i_gnt", o_i_gnt, 1);
    chk("f1_d_gnt", o_d_gnt, 0);
    chk("f1_mreq", o_mreq, 1);
    chk("f1_maddr", o_maddr, 32'h10);
    chk("f1_mwe", o_mwe, 0);
    step();
    i_req = 0;
    @(negedge clk);
    chk("f1_i_rvalid", o_i_rv, 1);
    chk("f1_i_rdata", o_i_rd, 32'hDEADBEEF);
    chk("f1_d_rvalid", o_d_rv, 0);
    step();

    // Continuous contention: I first, then strict alternation
    do_reset();
    i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h40;
    prev = -1;
    for (int t = 0; t < 6; t++) begin
      wait_gnt("alt", c);
      chk("alt_winner_is_d", o_d_gnt, 64'(t % 2));
      if (t > 0) chk("alt_spacing", 64'(c - prev), 2);
      prev = c;
      step();
    end
    i_req = 0; d_req = 0;
    repeat (4) step();

    // Back-to-back stores
    do_reset();
    d_req = 1; d_we = 1;
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'(4 * k); d_wdata = 32'(k + 1);
      @(negedge clk);
      chk("st_d_gnt", o_d_gnt, 1);
      chk("st_mreq", o_mreq, 1);
      chk("st_mwe", o_mwe, 1);
      chk("st_maddr", o_maddr, 32'(4 * k));
      chk("st_mwdata", o_mwd, 32'(k + 1));
      step();
    end
    d_req = 0; d_we = 0;
    repeat (3) begin
      @(negedge clk);
      chk("st_no_rvalid", o_d_rv, 0);
      step();
    end

    // Store then load the same word
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hA5;
    @(negedge clk);
    chk("rw_st_gnt", o_d_gnt, 1);
    step();
    d_we = 0;
    @(negedge clk);
    chk("rw_ld_gnt", o_d_gnt, 1);
    chk("rw_ld_mwe", o_mwe, 0);
    step();
    d_req = 0;
    @(negedge clk);
    chk("rw_d_rvalid", o_d_rv, 1);
    chk("rw_d_rdata", o_d_rd, 32'hA5);
    chk("rw_i_rvalid", o_i_rv, 0);
    step();

    // Latency 3: load at N, rvalid at N+3, pending fetch granted at N+4
    sel = 1;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h20;
    @(negedge clk);
    chk("l3_d_gnt", o_d_gnt, 1);
    n0 = cyc;
    step();
    d_req = 0; i_req = 1; i_addr = 32'h30;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("l3_cycle", 64'(cyc - n0), 64'(k));
      chk("l3_d_rvalid", o_d_rv, (k == 3));
      chk("l3_i_gnt", o_i_gnt, (k == 4));
      step();
    end
    i_req = 0;
    repeat (5) step();

    // Asynchronous reset during a latency-3 read
    do_reset();
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("ar_pre_i_gnt", o_i_gnt, 1);
    step();
    i_req = 0;
    rst_n = 1'b0;
    #1 chk("ar_async_outs", any_out(), 0);
    i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h24;
    @(posedge clk);
    @(negedge clk);
    chk("ar_held_outs", any_out(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_tie_i_gnt", o_i_gnt, 1);
    chk("ar_tie_d_gnt", o_d_gnt, 0);
    step();
    i_req = 0;
    wait_gnt("ar_d", c);
    chk("ar_d_gnt", o_d_gnt, 1);
    step();
    d_req = 0;
    repeat (5) step();

    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester (port I, read-only) and the data load/store requester (port D).
- Sits between the pc/fetch logic, the load/store path and a memory instance with a fixed read latency, replacing the separate imem/dmem arrangement.
- Allows one outstanding transaction at a time; round-robin arbitration on contention.
- Uses a req/gnt handshake with an rvalid read-response pulse.

Parameters:
DATAWIDTH, 32, width of data words
ADDRWIDTH, 32, width of byte addresses
MEM_LATENCY, 1, cycles from mem_req_o (read) to valid mem_rdata_i; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
i_req_i  in  1  fetch request; held with i_addr_i until granted
i_addr_i  in  ADDRWIDTH  fetch address
i_gnt_o  out  1  fetch request accepted this cycle
i_rvalid_o  out  1  fetch read data valid (1-cycle pulse)
i_rdata_o  out  DATAWIDTH  fetch read data
d_req_i  in  1  data request; held with d_we_i/d_addr_i/d_wdata_i until granted
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDRWIDTH  data address
d_wdata_i  in  DATAWIDTH  store data
d_gnt_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  load data valid (1-cycle pulse; never for stores)
d_rdata_o  out  DATAWIDTH  load data
mem_req_o  out  1  memory access strobe (1 cycle per transaction)
mem_we_o  out  1  memory write enable, qualified by mem_req_o
mem_addr_o  out  ADDRWIDTH  memory address
mem_wdata_o  out  DATAWIDTH  memory write data
mem_rdata_i  in  DATAWIDTH  memory read data, valid MEM_LATENCY cycles after a read mem_req_o

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0, owner=I, last_grant=D (so I wins the first tie).
  - All outputs 0.
  - A transaction in flight is abandoned: no rvalid is ever produced for it.
- FSM states: IDLE, WAIT.
- IDLE, no request: all outputs 0.
- IDLE, any req high: select a winner in the same cycle (combinational).
  - Only one requester high: that one wins.
  - Both high: the requester not recorded in last_grant wins.
  - Winner's gnt_o=1 and mem_req_o=1.
  - mem_we_o/mem_addr_o/mem_wdata_o pass through from the winner's inputs; port I always drives we=0 and wdata=0.
  - Loser's gnt_o=0; it must keep its request held.
  - Register last_grant<=winner and owner<=winner.
- Granted store: completes at grant; state stays IDLE, so a new grant is possible the next cycle. No rvalid.
- Granted load or fetch: next state is WAIT with counter<=1.
- WAIT:
  - gnt_o=0 on both ports and mem_req_o=0; requests are ignored and held.
  - Each cycle with counter<MEM_LATENCY: counter<=counter+1.
  - When counter==MEM_LATENCY: owner's rvalid_o=1 and owner's rdata_o=mem_rdata_i (combinational); next state IDLE.
- No grant in the rvalid cycle. Read throughput is one read per MEM_LATENCY+1 cycles; store throughput is one per cycle.
- rdata_o of a port is 0 whenever its rvalid_o is 0.
- Counter width is $clog2(MEM_LATENCY+1). The counter never wraps: the compare against MEM_LATENCY happens before any increment.
- A req dropped before gnt is a protocol violation and is not checked. The arbiter samples req only in IDLE.
- Starvation-free: under continuous requests from both ports, grants alternate I, D, I, D...
- At most one gnt_o and at most one rvalid_o are high in any cycle. gnt_o and rvalid_o are never high in the same cycle.

Test Plan:
- Reset then a single fetch, MEM_LATENCY=1: i_req_i=1, i_addr_i=0x10 at cycle 0 → i_gnt_o=1, mem_req_o=1, mem_addr_o=0x10, mem_we_o=0 at cycle 0; memory returns 0xDEADBEEF; i_rvalid_o=1 with i_rdata_o=0xDEADBEEF at cycle 1; d_rvalid_o=0 throughout.
- Simultaneous requests from reset, fetch 0x0 and load 0x40: I is granted first (last_grant reset=D); d_gnt_o=1 in the first IDLE cycle after I's rvalid; grants alternate I, D over 6 transactions.
- Store stream: d_req_i=1, d_we_i=1, addresses 0x0/0x4/0x8 with data 1/2/3 on consecutive cycles → mem_req_o and mem_we_o high on 3 consecutive cycles with matching address/data; d_rvalid_o stays 0.
- MEM_LATENCY=3 load of 0x20 → d_gnt_o at cycle N, d_rvalid_o only at cycle N+3; a fetch raised at N+1 is granted at N+4.
- Reset asserted at counter=1 of a MEM_LATENCY=3 read → all outputs 0 immediately (asynchronous); no rvalid after release; first post-reset tie goes to I.
- Read/write mix: store 0xA5 to 0x8, then load 0x8 → d_rdata_o=0xA5 with d_rvalid_o pulse; i_rvalid_o stays 0.
